// File: rtl/adc083000_snapshot_if.sv
// adc083000_snapshot_if: PHY user-data stream feeding the snapshot buffer
interface adc083000_snapshot_if;
  logic [63:0] adc_data;
  logic [3:0]  adc_sync;
  logic [3:0]  adc_outofrange;
  logic        adc_data_valid;
  modport master(output adc_data, adc_sync, adc_outofrange, adc_data_valid);
  modport slave(input adc_data, adc_sync, adc_outofrange, adc_data_valid);
endinterface

// File: rtl/adc083000_snapshot.sv
// adc083000_snapshot: pre/post-trigger ring capture of ADC083000 PHY words; ADC_SNAP_OOR_FLAG_EN stores out-of-range flags
module adc083000_snapshot #(
  parameter int ADDR_W   = 10,
  parameter int POST_LEN = 512
) (
  input  logic                adc_clk,
  input  logic                ctrl_reset,
  adc083000_snapshot_if.slave adc,
  input  logic                arm,
  input  logic                trig_sel,
  input  logic                trig,
  output logic                armed,
  output logic                done,
  output logic [ADDR_W-1:0]   trig_addr,
  output logic [ADDR_W:0]     pre_count,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [63:0]         rd_data
`ifdef ADC_SNAP_OOR_FLAG_EN
  ,
  output logic [3:0]          rd_oor,
  output logic                oor_seen
`endif
);
`ifdef ADC_SNAP_OOR_FLAG_EN
  localparam int W = 68;
`else
  localparam int W = 64;
`endif
  localparam logic [ADDR_W:0] PRE_MAX = (ADDR_W+1)'(2**ADDR_W - POST_LEN);
  localparam logic [ADDR_W:0] PL = (ADDR_W+1)'(POST_LEN);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t st, nxt;
  logic [W-1:0] mem [2**ADDR_W];
  logic [W-1:0] rd_q, wd;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0] post_cnt;
  logic sync_prev, ev, we, take;
`ifdef ADC_SNAP_OOR_FLAG_EN
  assign wd = {adc.adc_outofrange, adc.adc_data};
  assign rd_oor = rd_q[67:64];
`else
  assign wd = adc.adc_data;
`endif
  assign rd_data = rd_q[63:0];
  assign armed = st == ARMED;
  assign done = st == DONE;
  // trigger event, write enable and next state; arm overrides everything
  always_comb begin
    ev = trig_sel ? (|adc.adc_sync & ~sync_prev) : trig;
    we = ~arm & adc.adc_data_valid & (st == ARMED | st == CAPTURE);
    take = we & st == ARMED & ev;
    nxt = st;
    if (arm) nxt = ARMED;
    else if (take) nxt = POST_LEN == 1 ? DONE : CAPTURE;
    else if (we & st == CAPTURE & post_cnt == PL - ONE) nxt = DONE;
  end
  // state register, pointers, counters and sync edge history
  always_ff @(posedge adc_clk or posedge ctrl_reset)
    if (ctrl_reset) begin
      st <= IDLE;
      wr_ptr <= '0;
      post_cnt <= '0;
      pre_count <= '0;
      trig_addr <= '0;
      sync_prev <= 1'b0;
`ifdef ADC_SNAP_OOR_FLAG_EN
      oor_seen <= 1'b0;
`endif
    end else begin
      st <= nxt;
      if (arm) begin
        wr_ptr <= '0;
        pre_count <= '0;
        sync_prev <= 1'b0;
`ifdef ADC_SNAP_OOR_FLAG_EN
        oor_seen <= 1'b0;
`endif
      end else begin
        if (adc.adc_data_valid) sync_prev <= |adc.adc_sync;
        if (we) wr_ptr <= wr_ptr + 1'b1;
        if (we & st == ARMED & ~take & pre_count != PRE_MAX) pre_count <= pre_count + ONE;
        if (take) begin
          trig_addr <= wr_ptr;
          post_cnt <= ONE;
        end else if (we) post_cnt <= post_cnt + ONE;
`ifdef ADC_SNAP_OOR_FLAG_EN
        if (we) oor_seen <= oor_seen | (|adc.adc_outofrange);
`endif
      end
    end
  // ring RAM write port
  always_ff @(posedge adc_clk)
    if (we) mem[wr_ptr] <= wd;
  // registered read port
  always_ff @(posedge adc_clk or posedge ctrl_reset)
    if (ctrl_reset) rd_q <= '0;
    else rd_q <= mem[rd_addr];
endmodule

// File: tb/tb_adc083000_snapshot.sv
// tb_adc083000_snapshot: directed scoreboard bench for the snapshot buffer
module tb_adc083000_snapshot;
  localparam int AW = 4;
  localparam int PL = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  adc083000_snapshot_if a();
  logic arm = 1'b0, trig_sel = 1'b0, trig = 1'b0;
  logic armed, done;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] rd_addr = '0;
  logic [AW:0] pre_count;
  logic [63:0] rd_data;
`ifdef ADC_SNAP_OOR_FLAG_EN
  logic [3:0] rd_oor;
  logic oor_seen;
`endif
  adc083000_snapshot #(.ADDR_W(AW), .POST_LEN(PL)) dut (
    .adc_clk(clk), .ctrl_reset(rst), .adc(a), .arm(arm), .trig_sel(trig_sel), .trig(trig),
    .armed(armed), .done(done), .trig_addr(trig_addr), .pre_count(pre_count),
    .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef ADC_SNAP_OOR_FLAG_EN
    , .rd_oor(rd_oor), .oor_seen(oor_seen)
`endif
  );
  typedef struct {logic [63:0] d; logic [3:0] o;} rd_t;
  typedef struct {logic [AW-1:0] ta; logic [AW:0] pc;} st_t;
  rd_t rq[$];
  st_t sq[$];
  int total = 0, bad = 0;
  logic rd_req = 1'b0, rd_vld = 1'b0, done_q = 1'b0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic step(logic v, logic [63:0] d, logic [3:0] s, logic [3:0] o, logic t);
    a.adc_data_valid = v;
    a.adc_data = d;
    a.adc_sync = s;
    a.adc_outofrange = o;
    trig = t;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_arm();
    arm = 1'b1;
    step(0, 0, 0, 0, 0);
    arm = 1'b0;
  endtask
  task automatic rd(logic [AW-1:0] ad, logic [63:0] d, logic [3:0] o);
    rd_t e;
    e.d = d;
    e.o = o;
    rq.push_back(e);
    rd_addr = ad;
    rd_req = 1'b1;
    step(0, 0, 0, 0, 0);
    rd_req = 1'b0;
  endtask
  task automatic exp_st(logic [AW-1:0] ta, logic [AW:0] pc);
    st_t e;
    e.ta = ta;
    e.pc = pc;
    sq.push_back(e);
  endtask
  always @(posedge clk) rd_vld <= rd_req;
  always @(negedge clk) begin
    if (rd_vld) begin
      if (rq.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        rd_t e;
        e = rq.pop_front();
        chk("rd_data", rd_data, e.d);
`ifdef ADC_SNAP_OOR_FLAG_EN
        chk("rd_oor", {60'd0, rd_oor}, {60'd0, e.o});
`endif
      end
    end
    if (done && !done_q) begin
      if (sq.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        st_t e;
        e = sq.pop_front();
        chk("trig_addr", {60'd0, trig_addr}, {60'd0, e.ta});
        chk("pre_count", {59'd0, pre_count}, {59'd0, e.pc});
      end
    end
    done_q <= done;
  end
  initial begin
    a.adc_data = '0;
    a.adc_sync = '0;
    a.adc_outofrange = '0;
    a.adc_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_armed", {63'd0, armed}, 0);
    chk("rst_done", {63'd0, done}, 0);
    chk("rst_trig_addr", {60'd0, trig_addr}, 0);
    chk("rst_pre_count", {59'd0, pre_count}, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    pulse_arm();
    chk("t1_armed", {63'd0, armed}, 1);
    exp_st(15, 12);
    for (int n = 0; n < 20; n++) begin
      step(1, 64'(n), 0, 0, n == 15);
      if (n == 17) chk("t1_not_done_yet", {63'd0, done}, 0);
    end
    chk("t1_done_hold", {63'd0, done}, 1);
    rd(2, 18, 0);
    rd(3, 3, 0);
    rd(15, 15, 0);
    rd(0, 16, 0);
    trig_sel = 1'b1;
    pulse_arm();
    exp_st(3, 3);
    for (int n = 0; n < 10; n++) step(1, 64'h200 + 64'(n), n >= 3 ? 4'b0010 : 4'b0000, 0, 0);
    rd(3, 64'h203, 0);
    rd(6, 64'h206, 0);
    rd(7, 7, 0);
    trig_sel = 1'b0;
    pulse_arm();
    exp_st(2, 2);
    step(1, 64'h300, 0, 0, 0);
    step(0, 64'hEE, 0, 0, 1);
    step(1, 64'h301, 0, 0, 0);
    step(1, 64'h302, 0, 0, 1);
    for (int k = 3; k < 6; k++) begin
      step(0, 64'hEE, 0, 0, 1);
      step(1, 64'h300 + 64'(k), 0, 0, 0);
    end
    step(1, 64'h306, 0, 0, 0);
    rd(1, 64'h301, 0);
    rd(4, 64'h304, 0);
    rd(5, 64'h305, 0);
    rd(6, 64'h206, 0);
    arm = 1'b1;
    step(1, 64'hAA, 0, 0, 1);
    arm = 1'b0;
    chk("t4_armed", {63'd0, armed}, 1);
    exp_st(0, 0);
    for (int n = 0; n < 4; n++) step(1, 64'h400 + 64'(n), 0, 0, n == 0);
    rd(0, 64'h400, 0);
    rd(3, 64'h403, 0);
    pulse_arm();
    for (int n = 0; n < 5; n++) step(1, 64'h500 + 64'(n), 0, 0, n == 3);
    chk("t5_capture_armed", {63'd0, armed}, 0);
    chk("t5_capture_trig_addr", {60'd0, trig_addr}, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_armed", {63'd0, armed}, 0);
    chk("t5_rst_done", {63'd0, done}, 0);
    chk("t5_rst_trig_addr", {60'd0, trig_addr}, 0);
    chk("t5_rst_pre_count", {59'd0, pre_count}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 6; n++) step(1, 64'h5FF, 0, 0, 1);
    chk("t5_idle_armed", {63'd0, armed}, 0);
    chk("t5_idle_done", {63'd0, done}, 0);
`ifdef ADC_SNAP_OOR_FLAG_EN
    pulse_arm();
    chk("t6_oor_clear", {63'd0, oor_seen}, 0);
    exp_st(4, 4);
    for (int n = 0; n < 8; n++) step(1, 64'h600 + 64'(n), 0, n == 2 ? 4'b0100 : 4'b0000, n == 4);
    chk("t6_oor_seen", {63'd0, oor_seen}, 1);
    rd(2, 64'h602, 4'b0100);
    rd(3, 64'h603, 4'b0000);
    pulse_arm();
    chk("t6_oor_rearm", {63'd0, oor_seen}, 0);
`endif
    repeat (3) step(0, 0, 0, 0, 0);
    chk("rd_queue_empty", 64'(rq.size()), 0);
    chk("status_queue_empty", 64'(sq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
